fnd_scan_driver: RTL

Multiplexed 7-segment (FND) display driver that consumes the 3-digit segment bus produced by the BCD up/down counter and drives a common-cathode/anode-select display one digit at a time. It sits between the counter's segment output and the board pins. It inserts a blanking dead time between digits to suppress ghosting, and latches a full frame at a time so a mid-scan counter update never tears the display.

---
 rtl/fnd_scan_driver_pkg.sv | 18 +
 rtl/fnd_scan_driver_if.sv | 27 ++
 rtl/fnd_scan_timer.sv | 50 +++++
 rtl/fnd_scan_driver.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fnd_scan_driver_pkg.sv
// rtl/fnd_scan_driver_pkg.sv - shared constants, state type and sizing helper for the FND scan driver
package fnd_pkg;

  // gfedcba pattern of the digit "0" and of a dark digit
  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Width of an index covering 0..n-1, never less than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fnd_scan_driver_if.sv
// rtl/fnd_scan_driver_if.sv - segment bus in, multiplexed digit drive out
interface fnd_scan_driver_if #(
  parameter int NUM_DIGITS = 3
) ();

  logic [7*NUM_DIGITS-1:0] Fnd_i;
  logic [6:0]              Seg_o;
  logic [NUM_DIGITS-1:0]   Com_o;
  logic                    Frame_o;

  // Pattern source side (counter / bench)
  modport master (
    output Fnd_i,
    input  Seg_o,
    input  Com_o,
    input  Frame_o
  );

  // Display driver side
  modport slave (
    input  Fnd_i,
    output Seg_o,
    output Com_o,
    output Frame_o
  );

endinterface

// File: rtl/fnd_scan_timer.sv
// rtl/fnd_scan_timer.sv - slot counter and digit index with wrap and show-start strobes
module fnd_scan_timer
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50,
  localparam int DIG_W       = idx_width(NUM_DIGITS)
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic [DIG_W-1:0] dig,
  output logic             wrap,
  output logic             show_start
);

  localparam int CNT_W = idx_width(SCAN_DIV);

  logic [CNT_W-1:0] cnt;

  // Strobes are decoded from the current count, so they mark the edge on
  // which the slot wraps or the dead time ends.
  assign wrap       = (cnt == CNT_W'(SCAN_DIV - 1));
  assign show_start = (cnt == CNT_W'(BLANK_CYCLES - 1));

  // Slot counter: 0..SCAN_DIV-1, restarting on wrap
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index advances once per slot and rolls over after the last digit
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      dig <= '0;
    end else if (wrap) begin
      if (dig == DIG_W'(NUM_DIGITS - 1)) begin
        dig <= '0;
      end else begin
        dig <= dig + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - multiplexed 7-segment driver with dead time and frame latch; FND_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic              Clk,
  input  logic              Rst,
  fnd_scan_driver_if.slave  bus
);

  localparam int DIG_W = idx_width(NUM_DIGITS);
  localparam int BUS_W = 7 * NUM_DIGITS;

  logic [DIG_W-1:0] dig;
  logic             wrap;
  logic             show_start;
  logic             load;

  state_t           state_q;
  state_t           state_nxt;

  logic [BUS_W-1:0] fbuf_q;
  logic [BUS_W-1:0] fbuf_nxt;
  logic [BUS_W-1:0] fnd_eff;

  logic [6:0]            seg_q;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] com_q;
  logic [NUM_DIGITS-1:0] com_nxt;
  logic                  frame_q;
  logic                  frame_nxt;

  fnd_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .dig        (dig),
    .wrap       (wrap),
    .show_start (show_start)
  );

  // A new frame is captured only when digit 0 leaves its dead time
  assign load = show_start && (dig == '0);

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Darken zero digits from the top down until the first non-zero digit;
  // digit 0 is never touched so a value of zero still shows "0".
  always_comb begin
    logic higher_zero;
    fnd_eff     = bus.Fnd_i;
    higher_zero = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      if (higher_zero && (bus.Fnd_i[7*d +: 7] == SEG_ZERO)) begin
        fnd_eff[7*d +: 7] = SEG_OFF;
      end else begin
        higher_zero = 1'b0;
      end
    end
  end
`else
  // Frame buffer takes the counter's patterns verbatim
  always_comb begin
    fnd_eff = bus.Fnd_i;
  end
`endif

  // Next state: the dead time ends on show_start, the slot ends on wrap
  always_comb begin
    state_nxt = state_q;
    if (wrap) begin
      state_nxt = ST_BLANK;
    end else if (show_start) begin
      state_nxt = ST_SHOW;
    end
  end

  // Next outputs follow the next state so Com_o and Seg_o switch on the same
  // edge; the freshly loaded frame is visible in the very first SHOW cycle.
  always_comb begin
    fbuf_nxt  = load ? fnd_eff : fbuf_q;
    seg_nxt   = SEG_OFF;
    com_nxt   = '1;
    frame_nxt = load;
    if (state_nxt == ST_SHOW) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (dig == DIG_W'(d)) begin
          com_nxt[d] = 1'b0;
          seg_nxt    = fbuf_nxt[7*d +: 7];
        end
      end
    end
  end

  // State, frame buffer and registered pin drive; reset darkens the display at once
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_BLANK;
      fbuf_q  <= '0;
      seg_q   <= SEG_OFF;
      com_q   <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      fbuf_q  <= fbuf_nxt;
      seg_q   <= seg_nxt;
      com_q   <= com_nxt;
      frame_q <= frame_nxt;
    end
  end

  assign bus.Seg_o   = seg_q;
  assign bus.Com_o   = com_q;
  assign bus.Frame_o = frame_q;

endmodule
